// File: rtl/bist_ctrl_multi.sv
// Logic-BIST controller for N_CHAINS parallel scan chains: one Galois LFSR
// supplies the patterns, a MISR compacts the chain outputs and the final signature is checked against GOLDEN_SIG.
module bist_ctrl_multi #(
    parameter int unsigned          N_CHAINS   = 1,
    parameter int unsigned          CHAIN_LEN  = 8,
    parameter int unsigned          N_PATTERNS = 16,
    parameter int unsigned          LFSR_W     = 16,
    parameter logic [LFSR_W-1:0]    LFSR_POLY  = 16'h002D,
    parameter logic [LFSR_W-1:0]    LFSR_SEED  = 16'hACE1,
    parameter int unsigned          MISR_W     = 16,
    parameter logic [MISR_W-1:0]    MISR_POLY  = 16'h1021,
    parameter logic [MISR_W-1:0]    GOLDEN_SIG = 16'h0000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                bist_start,
    output logic                scan_en,
    output logic                test_mode,
    output logic [N_CHAINS-1:0] scan_in,
    input  logic [N_CHAINS-1:0] scan_out,
    output logic [MISR_W-1:0]   signature,
    output logic                busy,
    output logic                bist_end,
    output logic                pass_fail
);

    localparam int unsigned BW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned PW = $clog2(N_PATTERNS + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);
    localparam logic [PW-1:0] PAT_LAST = PW'(N_PATTERNS);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_SHIFT, S_CAPTURE, S_UNLOAD, S_COMPARE, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [MISR_W-1:0]   misr_q, misr_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [PW-1:0]       pat_q, pat_d;
    logic                end_q, end_d;
    logic                pf_q, pf_d;
    logic                advance, compact;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            misr_q  <= '0;
            bit_q   <= '0;
            pat_q   <= '0;
            end_q   <= 1'b0;
            pf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            bit_q   <= bit_d;
            pat_q   <= pat_d;
            end_q   <= end_d;
            pf_q    <= pf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        misr_d    = misr_q;
        bit_d     = bit_q;
        pat_d     = pat_q;
        end_d     = end_q;
        pf_d      = pf_q;
        scan_en   = 1'b0;
        test_mode = 1'b0;
        busy      = 1'b0;
        advance   = 1'b0;
        compact   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bist_start) begin
                    state_d = S_INIT;
                    end_d   = 1'b0;
                    pf_d    = 1'b0;
                end
            end
            S_INIT: begin
                test_mode = 1'b1;
                busy      = 1'b1;
                lfsr_d    = LFSR_SEED;
                misr_d    = '0;
                bit_d     = '0;
                pat_d     = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                test_mode = 1'b1;
                busy      = 1'b1;
                scan_en   = 1'b1;
                advance   = 1'b1;
                // First pattern unloads power-up garbage; keep it out of the MISR
                compact   = (pat_q != '0);
                if (bit_q == BIT_LAST) begin
                    bit_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                test_mode = 1'b1;
                busy      = 1'b1;
                pat_d     = pat_q + 1'b1;
                state_d   = (pat_d == PAT_LAST) ? S_UNLOAD : S_SHIFT;
            end
            S_UNLOAD: begin
                test_mode = 1'b1;
                busy      = 1'b1;
                scan_en   = 1'b1;
                advance   = 1'b1;
                compact   = 1'b1;
                if (bit_q == BIT_LAST) begin
                    bit_d   = '0;
                    state_d = S_COMPARE;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            S_COMPARE: begin
                test_mode = 1'b1;
                busy      = 1'b1;
                pf_d      = (misr_q == GOLDEN_SIG);
                end_d     = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (!bist_start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (advance)
            lfsr_d = {lfsr_q[LFSR_W-2:0], 1'b0} ^ (lfsr_q[LFSR_W-1] ? LFSR_POLY : '0);
        if (compact)
            misr_d = ({misr_q[MISR_W-2:0], 1'b0} ^ (misr_q[MISR_W-1] ? MISR_POLY : '0))
                     ^ MISR_W'(scan_out);

        // Chains only see LFSR data while the BIST path is selected
        scan_in = test_mode ? lfsr_q[N_CHAINS-1:0] : '0;
    end

    assign signature = misr_q;
    assign bist_end  = end_q;
    assign pass_fail = pf_q;

endmodule

// File: tb/tb_bist_ctrl_multi.sv
// Directed bench for bist_ctrl_multi: a 4x4 scan-chain CUT model drives scan_out,
// and a reference model of the full run supplies GOLDEN_SIG.
module tb_bist_ctrl_multi;

    localparam int NC  = 4;
    localparam int CL  = 4;
    localparam int NP  = 3;
    localparam int LAT = 2 + NP * (CL + 1) + CL;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam logic [15:0] LPOLY = 16'h002D;
    localparam logic [15:0] MPOLY = 16'h1021;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], 1'b0} ^ (l[15] ? LPOLY : 16'h0000);
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [3:0] so);
        return ({m[14:0], 1'b0} ^ (m[15] ? MPOLY : 16'h0000)) ^ {12'h000, so};
    endfunction

    // Chain c occupies bits [c*CL +: CL]; bit 0 is the scan-in end.
    function automatic logic [15:0] cut_shift(input logic [15:0] x, input logic [3:0] si);
        logic [15:0] r;
        r = x;
        for (int c = 0; c < NC; c++) r[c*CL +: CL] = {x[c*CL +: CL-1], si[c]};
        return r;
    endfunction

    function automatic logic [3:0] cut_out(input logic [15:0] x);
        logic [3:0] o;
        for (int c = 0; c < NC; c++) o[c] = x[c*CL + CL - 1];
        return o;
    endfunction

    function automatic logic [15:0] cut_cap(input logic [15:0] x);
        return {x[10:0], x[15:11]} ^ {2'b00, x[15:2]} ^ 16'h5A3C;
    endfunction

    // Chain 2, flop 1 stuck-at-0
    function automatic logic [15:0] apply_fault(input logic [15:0] x, input logic f);
        logic [15:0] r;
        r = x;
        if (f) r[2*CL + 1] = 1'b0;
        return r;
    endfunction

    function automatic logic [15:0] model_sig(input logic f);
        logic [15:0] l, m, x;
        l = SEED;
        m = 16'h0000;
        x = 16'h0000;
        for (int p = 0; p < NP; p++) begin
            for (int b = 0; b < CL; b++) begin
                if (p != 0) m = misr_step(m, cut_out(x));
                x = apply_fault(cut_shift(x, l[3:0]), f);
                l = lfsr_step(l);
            end
            x = apply_fault(cut_cap(x), f);
        end
        for (int b = 0; b < CL; b++) begin
            m = misr_step(m, cut_out(x));
            x = apply_fault(cut_shift(x, l[3:0]), f);
            l = lfsr_step(l);
        end
        return m;
    endfunction

    localparam logic [15:0] GOLDEN = model_sig(1'b0);

    logic        CLK, RST, bist_start;
    logic        scan_en, test_mode, busy, bist_end, pass_fail;
    logic [3:0]  scan_in, scan_out;
    logic [15:0] signature;
    logic [15:0] cut_q;
    logic        cut_scramble, fault_en;
    int          checks, errors;

    bist_ctrl_multi #(
        .N_CHAINS   (NC),
        .CHAIN_LEN  (CL),
        .N_PATTERNS (NP),
        .GOLDEN_SIG (GOLDEN)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bist_start (bist_start),
        .scan_en    (scan_en),
        .test_mode  (test_mode),
        .scan_in    (scan_in),
        .scan_out   (scan_out),
        .signature  (signature),
        .busy       (busy),
        .bist_end   (bist_end),
        .pass_fail  (pass_fail)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (cut_scramble)
            cut_q <= 'x;
        else if (test_mode)
            cut_q <= scan_en ? apply_fault(cut_shift(cut_q, scan_in), fault_en)
                             : apply_fault(cut_cap(cut_q), fault_en);
    end
    assign scan_out = cut_out(cut_q);

    task automatic scramble_cut();
        cut_scramble = 1'b1;
        @(negedge CLK);
        cut_scramble = 1'b0;
    endtask

    task automatic pulse_start();
        bist_start = 1'b1;
        @(negedge CLK);
        bist_start = 1'b0;
    endtask

    task automatic wait_end(output int n);
        n = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge CLK);
            if (bist_end === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bist_start = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if ({scan_en, test_mode, busy, bist_end, pass_fail} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {scan_en, test_mode, busy, bist_end, pass_fail});
        end
        checks++;
        if (scan_in !== 4'h0) begin
            errors++;
            $display("FAIL reset_scan_in: got %h expected 0", scan_in);
        end
        checks++;
        if (signature !== 16'h0000) begin
            errors++;
            $display("FAIL reset_signature: got %h expected 0000", signature);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({busy, test_mode, scan_en} !== 3'b110) begin
            errors++;
            $display("FAIL init_entry: got busy/tm/se=%b expected 110", {busy, test_mode, scan_en});
        end
        @(negedge CLK);
        checks++;
        if (scan_en !== 1'b1 || scan_in !== SEED[3:0]) begin
            errors++;
            $display("FAIL shift_after_init: got se=%b si=%h expected se=1 si=%h", scan_en, scan_in, SEED[3:0]);
        end
        bist_start = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_fault_free_run();
        logic [19:0] tr, exp_tr;
        logic [3:0]  first_si;
        int          end_at, busy_bad;
        tr = '0;
        exp_tr = '0;
        first_si = 4'h0;
        end_at = -1;
        busy_bad = 0;
        for (int k = 1; k < 20; k++) exp_tr[k] = ((k % (CL + 1)) != 0);
        fault_en = 1'b0;
        scramble_cut();
        pulse_start();
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLK);
            if (k == 1) first_si = scan_in;
            if (k < 20) tr[k] = scan_en;
            if (k < LAT && (busy !== 1'b1 || test_mode !== 1'b1)) busy_bad++;
            if (bist_end === 1'b1) begin
                end_at = k;
                break;
            end
        end
        checks++;
        if (end_at != LAT) begin
            errors++;
            $display("FAIL end_latency: got %0d edges expected %0d", end_at, LAT);
        end
        checks++;
        if (tr !== exp_tr) begin
            errors++;
            $display("FAIL scan_en_trace: got %b expected %b", tr, exp_tr);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL busy_during_run: got %0d low cycles expected 0", busy_bad);
        end
        checks++;
        if (first_si !== SEED[3:0]) begin
            errors++;
            $display("FAIL first_scan_in: got %h expected %h", first_si, SEED[3:0]);
        end
        checks++;
        if (pass_fail !== 1'b1 || signature !== GOLDEN) begin
            errors++;
            $display("FAIL good_signature: got pf=%b sig=%h expected pf=1 sig=%h", pass_fail, signature, GOLDEN);
        end
        checks++;
        if (busy !== 1'b0 || test_mode !== 1'b0) begin
            errors++;
            $display("FAIL done_state: got busy/tm=%b%b expected 00", busy, test_mode);
        end
        @(negedge CLK);
        checks++;
        if ({busy, bist_end, pass_fail} !== 3'b011) begin
            errors++;
            $display("FAIL idle_hold: got busy/end/pf=%b expected 011", {busy, bist_end, pass_fail});
        end
    endtask

    task automatic test_stuck_fault();
        int n;
        logic [15:0] exp_sig;
        exp_sig = model_sig(1'b1);
        fault_en = 1'b1;
        scramble_cut();
        pulse_start();
        wait_end(n);
        checks++;
        if (n != LAT) begin
            errors++;
            $display("FAIL fault_run_end: got %0d edges expected %0d", n, LAT);
        end
        checks++;
        if (pass_fail !== 1'b0 || signature === GOLDEN) begin
            errors++;
            $display("FAIL fault_detect: got pf=%b sig=%h expected pf=0 sig!=%h", pass_fail, signature, GOLDEN);
        end
        checks++;
        if (signature !== exp_sig) begin
            errors++;
            $display("FAIL fault_signature: got %h expected %h", signature, exp_sig);
        end
        fault_en = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset_midrun();
        int n;
        scramble_cut();
        pulse_start();
        repeat (7) @(negedge CLK);
        checks++;
        if (scan_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pattern2_shift: got se/busy=%b%b expected 11", scan_en, busy);
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if ({busy, test_mode, scan_en, bist_end} !== 4'b0000 || signature !== 16'h0000) begin
            errors++;
            $display("FAIL midrun_reset: got busy/tm/se/end=%b sig=%h expected 0000 sig=0000",
                     {busy, test_mode, scan_en, bist_end}, signature);
        end
        scramble_cut();
        pulse_start();
        wait_end(n);
        checks++;
        if (n != LAT || pass_fail !== 1'b1 || signature !== GOLDEN) begin
            errors++;
            $display("FAIL restart_signature: got n=%0d pf=%b sig=%h expected n=%0d pf=1 sig=%h",
                     n, pass_fail, signature, LAT, GOLDEN);
        end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        int n;
        scramble_cut();
        bist_start = 1'b1;
        @(negedge CLK);
        wait_end(n);
        checks++;
        if (n != LAT) begin
            errors++;
            $display("FAIL hold_run_end: got %0d edges expected %0d", n, LAT);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if ({bist_end, busy, test_mode} !== 3'b100) begin
            errors++;
            $display("FAIL done_hold: got end/busy/tm=%b expected 100", {bist_end, busy, test_mode});
        end
        bist_start = 1'b0;
        @(negedge CLK);
        bist_start = 1'b1;
        @(negedge CLK);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_drop: got busy=%b expected 1", busy);
        end
        wait_end(n);
        checks++;
        if (n != LAT || signature !== GOLDEN || pass_fail !== 1'b1) begin
            errors++;
            $display("FAIL second_run: got n=%0d sig=%h pf=%b expected n=%0d sig=%h pf=1",
                     n, signature, pass_fail, LAT, GOLDEN);
        end
        bist_start = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST = 1'b1;
        bist_start = 1'b0;
        cut_scramble = 1'b0;
        fault_en = 1'b0;
        test_reset();
        test_fault_free_run();
        test_stuck_fault();
        test_reset_midrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bist_ctrl_multi.md
Name: bist_ctrl_multi

Overview:
- Parametrised logic-BIST controller; successor to the single-chain BIST in `main`.
- Drives N_CHAINS parallel scan chains of the circuit under test (CUT) from one LFSR pattern generator, and compacts chain outputs into a MISR.
- Runs N_PATTERNS shift/capture cycles, then compares the final signature with GOLDEN_SIG and reports pass/fail.
- Sits between the top-level test pins (bist_start, bist_end, pass_fail) and the CUT scan/test-mode muxes.

Parameters:
- N_CHAINS, 1, number of parallel scan chains (1..LFSR_W, 1..MISR_W).
- CHAIN_LEN, 8, flops per chain (>=1).
- N_PATTERNS, 16, patterns applied per run (>=1).
- LFSR_W, 16, LFSR width.
- LFSR_POLY, 16'h002D, Galois feedback mask.
- LFSR_SEED, 16'hACE1, nonzero seed.
- MISR_W, 16, MISR width.
- MISR_POLY, 16'h1021, MISR feedback mask.
- GOLDEN_SIG, 16'h0000, expected final signature.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- bist_start  in  1  level request to run.
- scan_en  out  N/A→1  CUT scan-enable (1 = shift, 0 = capture).
- test_mode  out  1  selects the BIST path in the CUT muxes.
- scan_in  out  N_CHAINS  serial data into each chain.
- scan_out  in  N_CHAINS  serial data out of each chain.
- signature  out  MISR_W  current MISR contents.
- busy  out  1  high in every state except IDLE and DONE.
- bist_end  out  1  run finished.
- pass_fail  out  1  1 = signature matched (valid while bist_end = 1).

Behaviour:
- Single clock; reset is synchronous and active-high on the port named RST, clock port named CLK.
- Reset values: state = IDLE; lfsr = LFSR_SEED; misr = 0; counters = 0; all outputs = 0. This holds regardless of state, so RST mid-run aborts to IDLE on the next edge.
- FSM states: IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE.
  - IDLE: when bist_start = 1 is sampled, go to INIT.
  - INIT: lasts 1 cycle. Loads lfsr = LFSR_SEED, misr = 0, pattern count = 0, bit count = 0; sets test_mode = 1 and clears bist_end and pass_fail. Then go to SHIFT.
  - SHIFT: scan_en = 1 for exactly CHAIN_LEN cycles, then go to CAPTURE.
  - CAPTURE: scan_en = 0 for 1 cycle; pattern count increments. If the incremented count equals N_PATTERNS, go to UNLOAD, else go to SHIFT.
  - UNLOAD: scan_en = 1 for CHAIN_LEN cycles, then go to COMPARE.
  - COMPARE: 1 cycle; registers pass_fail = (misr == GOLDEN_SIG). Then go to DONE.
  - DONE: bist_end = 1; test_mode = 0; pass_fail held. Stay while bist_start = 1; return to IDLE when bist_start = 0.
- pass_fail and bist_end keep their values in IDLE until the next INIT.
- test_mode is 1 in INIT, SHIFT, CAPTURE, UNLOAD and COMPARE.
- scan_in[c] = lfsr[c], combinational from the register.
- LFSR advances once per SHIFT and UNLOAD cycle (Galois): lfsr ← {lfsr[W-2:0],0} ^ (lfsr[W-1] ? LFSR_POLY : 0).
- MISR updates in SHIFT cycles of patterns 2..N_PATTERNS and in every UNLOAD cycle, i.e. N_PATTERNS×CHAIN_LEN updates total:
  - misr ← ({misr[W-2:0],0} ^ (misr[W-1] ? MISR_POLY : 0)) ^ zero-extended scan_out.
  - The first pattern's shift-out is CUT power-up garbage and is never compacted.
- Latency: bist_end rises exactly 2 + N_PATTERNS×(CHAIN_LEN+1) + CHAIN_LEN edges after the edge that samples bist_start in IDLE.
- bist_start deasserting mid-run is ignored; the run completes.
- scan_out X during non-compacting cycles must not reach misr.
- Counters are sized with $clog2 and wrap is never reached; the terminal compares are equality on the parameter values.

Test Plan:
- RST = 1 for 2 cycles with bist_start = 1 → all outputs 0 and state IDLE; after RST drops, INIT entered on the next edge.
- CHAIN_LEN = 4, N_PATTERNS = 3: start pulse → bist_end rises exactly 21 edges after the sampling edge; scan_en low on exactly 3 isolated cycles; busy = 1 throughout the run.
- Fault-free run:
  - Stimulus: N_CHAINS = 4; bench-modelled shift-register chains plus a fixed combinational capture function; GOLDEN_SIG computed by the bench reference model.
  - Response: pass_fail = 1, signature == GOLDEN_SIG, first scan_in vector == LFSR_SEED[3:0].
- Same setup with chain 2, bit 1 stuck-at-0 → pass_fail = 0 and signature ≠ GOLDEN_SIG.
- RST asserted during pattern 2 SHIFT → next edge: IDLE, test_mode = 0, signature = 0. A restart then reproduces the fault-free signature.
- bist_start held high through DONE → stays in DONE with bist_end = 1. Drop bist_start → IDLE next edge. Re-raise it → second run gives an identical signature.
